mem_feed_ctrl: RTL

Sequencing controller for the 4x4 operand memory of the Mini-TPU. It accepts a 16-element row-major load stream over a valid/ready handshake and drives the memory write port. On command, it drives the four read columns in a diagonally skewed pattern over 7 cycles, which feeds the systolic array. Its outputs connect directly to the memory's write/read control ports, and it guarantees that load and feed never overlap.

---
 rtl/mem_feed_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_feed_ctrl.sv
// Load/feed sequencer for the Mini-TPU 4x4 operand memory: row-major write stream in,
// diagonally skewed column reads out; load and feed are mutually exclusive by construction.
module mem_feed_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  feed_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  busy,
    output logic                  load_done,
    output logic                  feed_done,
    output logic                  feed_valid,
    output logic                  mem_write_enable,
    output logic [1:0]            mem_write_line,
    output logic [1:0]            mem_write_elem,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [3:0]            mem_read_enable,
    output logic [7:0]            mem_read_elem
);
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED} state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_idx, w_idx_next;
    logic [2:0] r_t, w_t_next;
    logic       r_load_done, w_load_done_next;
    logic       r_feed_done, w_feed_done_next;
    logic       w_in_load, w_in_feed, w_beat;

    assign w_in_load = (r_state == S_LOAD);
    assign w_in_feed = (r_state == S_FEED);
    assign w_beat    = w_in_load && ld_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_t         <= '0;
            r_load_done <= 1'b0;
            r_feed_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_t         <= w_t_next;
            r_load_done <= w_load_done_next;
            r_feed_done <= w_feed_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_t_next         = r_t;
        w_load_done_next = 1'b0;
        w_feed_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                // load has priority; a simultaneous feed request is simply dropped
                if (load_start) begin
                    w_state_next = S_LOAD;
                    w_idx_next   = '0;
                end else if (feed_start) begin
                    w_state_next = S_FEED;
                    w_t_next     = '0;
                end
            end
            S_LOAD: begin
                if (w_beat) begin
                    if (r_idx == 4'd15) begin
                        w_state_next     = S_IDLE;
                        w_idx_next       = '0;
                        w_load_done_next = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                    end
                end
            end
            S_FEED: begin
                if (r_t == 3'd6) begin
                    w_state_next     = S_IDLE;
                    w_t_next         = '0;
                    w_feed_done_next = 1'b1;
                end else begin
                    w_t_next = r_t + 3'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign ld_ready         = w_in_load;
    assign busy             = (r_state != S_IDLE);
    assign load_done        = r_load_done;
    assign feed_done        = r_feed_done;
    assign feed_valid       = w_in_feed;
    assign mem_write_enable = w_beat;
    assign mem_write_line   = w_in_load ? r_idx[3:2] : 2'b00;
    assign mem_write_elem   = w_in_load ? r_idx[1:0] : 2'b00;
    assign mem_data_in      = w_in_load ? ld_data : '0;

    // Column c is live for t in [c, c+3] and reads row t-c, giving the diagonal skew.
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
        logic [2:0] w_diff;
        logic       w_en;
        assign w_diff = r_t - 3'(gc);
        assign w_en   = w_in_feed && (r_t >= 3'(gc)) && (w_diff <= 3'd3);
        assign mem_read_enable[gc]      = w_en;
        assign mem_read_elem[2*gc +: 2] = w_en ? w_diff[1:0] : 2'b00;
    end
endmodule
